// File: rtl/game_engine_nxn.sv
// rtl/game_engine_nxn.sv - N x N tic-tac-toe match engine with scoring, result hold and match end
module game_engine_nxn #(
    parameter  int N           = 3,
    parameter  int WIN_SCORE   = 2,
    parameter  int HOLD_CYCLES = 4,
    localparam int NN          = N * N,
    localparam int SW          = $clog2(WIN_SCORE + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [NN-1:0] C,
    input  logic          writeEn,
    output logic [NN-1:0] X,
    output logic [NN-1:0] O,
    output logic          turn,
    output logic [SW-1:0] scorex,
    output logic [SW-1:0] scoreo,
    output logic          round_done,
    output logic          draw,
    output logic          illegal,
    output logic          gameOver
);

    localparam int CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    typedef enum logic [1:0] {
        S_PLAY   = 2'd0,
        S_RESULT = 2'd1,
        S_OVER   = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic            armed;
    logic            first;
    logic [CW-1:0]   cnt;

    // kind: 0 = row k, 1 = column k, 2 = main diagonal, 3 = anti-diagonal
    function automatic logic [NN-1:0] line_mask(input int kind, input int k);
        logic [NN-1:0] m;
        m = '0;
        for (int t = 0; t < N; t++) begin
            case (kind)
                0:       m[k*N + t]         = 1'b1;
                1:       m[t*N + k]         = 1'b1;
                2:       m[t*N + t]         = 1'b1;
                default: m[t*N + N - 1 - t] = 1'b1;
            endcase
        end
        return m;
    endfunction

    logic [N-1:0] x_row, x_col, o_row, o_col;
    logic [1:0]   x_diag, o_diag;

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_line
            localparam logic [NN-1:0] ROW_M = line_mask(0, gi);
            localparam logic [NN-1:0] COL_M = line_mask(1, gi);
            assign x_row[gi] = ((X & ROW_M) == ROW_M);
            assign x_col[gi] = ((X & COL_M) == COL_M);
            assign o_row[gi] = ((O & ROW_M) == ROW_M);
            assign o_col[gi] = ((O & COL_M) == COL_M);
        end
        for (gi = 0; gi < 2; gi++) begin : g_diag
            localparam logic [NN-1:0] DIAG_M = line_mask(2 + gi, 0);
            assign x_diag[gi] = ((X & DIAG_M) == DIAG_M);
            assign o_diag[gi] = ((O & DIAG_M) == DIAG_M);
        end
    endgenerate

    logic x_win, o_win, full, one_hot, legal, hold_done, x_final, o_final;

    assign x_win     = |{x_row, x_col, x_diag};
    assign o_win     = |{o_row, o_col, o_diag};
    assign full      = &(X | O);
    assign one_hot   = (C != '0) && ((C & (C - NN'(1))) == '0);
    assign legal     = one_hot && ((C & (X | O)) == '0);
    assign hold_done = (cnt == CW'(HOLD_CYCLES - 1));
    assign x_final   = (scorex == SW'(WIN_SCORE - 1));
    assign o_final   = (scoreo == SW'(WIN_SCORE - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_PLAY;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_PLAY: begin
                if (x_win) begin
                    state_nxt = x_final ? S_OVER : S_RESULT;
                end else if (o_win) begin
                    state_nxt = o_final ? S_OVER : S_RESULT;
                end else if (full) begin
                    state_nxt = S_RESULT;
                end
            end
            S_RESULT: begin
                if (hold_done) begin
                    state_nxt = S_PLAY;
                end
            end
            S_OVER:   state_nxt = S_OVER;
            default:  state_nxt = S_PLAY;
        endcase
    end

    always_comb begin
        round_done = 1'b0;
        gameOver   = 1'b0;
        case (state)
            S_RESULT: round_done = 1'b1;
            S_OVER:   gameOver   = 1'b1;
            default:  ;
        endcase
    end

    // Win/draw checks outrank the move, so a strobe on the detect edge is dropped.
    always_ff @(posedge clk) begin
        if (reset) begin
            X       <= '0;
            O       <= '0;
            turn    <= 1'b0;
            first   <= 1'b0;
            scorex  <= '0;
            scoreo  <= '0;
            draw    <= 1'b0;
            illegal <= 1'b0;
            armed   <= 1'b0;
            cnt     <= '0;
        end else begin
            illegal <= 1'b0;
            case (state)
                S_PLAY: begin
                    armed <= ~writeEn;
                    if (x_win) begin
                        if (scorex != SW'(WIN_SCORE)) begin
                            scorex <= scorex + SW'(1);
                        end
                    end else if (o_win) begin
                        if (scoreo != SW'(WIN_SCORE)) begin
                            scoreo <= scoreo + SW'(1);
                        end
                    end else if (full) begin
                        draw <= 1'b1;
                    end else if (armed && writeEn) begin
                        if (legal) begin
                            if (turn) begin
                                O <= O | C;
                            end else begin
                                X <= X | C;
                            end
                            turn <= ~turn;
                        end else begin
                            illegal <= 1'b1;
                        end
                    end
                end
                S_RESULT: begin
                    if (hold_done) begin
                        X     <= '0;
                        O     <= '0;
                        draw  <= 1'b0;
                        first <= ~first;
                        turn  <= ~first;
                        armed <= 1'b0;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_game_engine_nxn.sv
// tb/tb_game_engine_nxn.sv - directed and randomized bench for game_engine_nxn against a cell-level model
module tb_game_engine_nxn;

    localparam int N  = 3;
    localparam int NN = N * N;
    localparam int WS = 2;
    localparam int HC = 4;
    localparam int SW = $clog2(WS + 1);
    localparam int VW = 2 * NN + 2 * SW + 5;

    localparam int PH_PLAY = 0;
    localparam int PH_RES  = 1;
    localparam int PH_OVER = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic [NN-1:0] C;
    logic          writeEn;
    logic [NN-1:0] X;
    logic [NN-1:0] O;
    logic          turn;
    logic [SW-1:0] scorex;
    logic [SW-1:0] scoreo;
    logic          round_done;
    logic          draw;
    logic          illegal;
    logic          gameOver;

    int n_cmp;
    int n_bad;

    always #5 clk = ~clk;

    game_engine_nxn #(.N(N), .WIN_SCORE(WS), .HOLD_CYCLES(HC)) dut (
        .clk        (clk),
        .reset      (reset),
        .C          (C),
        .writeEn    (writeEn),
        .X          (X),
        .O          (O),
        .turn       (turn),
        .scorex     (scorex),
        .scoreo     (scoreo),
        .round_done (round_done),
        .draw       (draw),
        .illegal    (illegal),
        .gameOver   (gameOver)
    );

    logic [VW-1:0] dut_vec;
    assign dut_vec = {X, O, turn, scorex, scoreo, round_done, draw, illegal, gameOver};

    // Model: each cell holds 0 (empty), 1 (X) or 2 (O)
    int m_cell [NN];
    int m_sx, m_so, m_phase, m_hold;
    bit m_turn, m_armed, m_first, m_draw, m_ill;

    function automatic bit has_line(input int p);
        bit all_r, all_c, d0, d1;
        d0 = 1'b1;
        d1 = 1'b1;
        for (int r = 0; r < N; r++) begin
            all_r = 1'b1;
            all_c = 1'b1;
            for (int k = 0; k < N; k++) begin
                if (m_cell[r*N + k] != p) all_r = 1'b0;
                if (m_cell[k*N + r] != p) all_c = 1'b0;
            end
            if (all_r || all_c) return 1'b1;
        end
        for (int k = 0; k < N; k++) begin
            if (m_cell[k*N + k] != p)         d0 = 1'b0;
            if (m_cell[k*N + N - 1 - k] != p) d1 = 1'b0;
        end
        return d0 || d1;
    endfunction

    function automatic void clear_cells();
        for (int i = 0; i < NN; i++) m_cell[i] = 0;
    endfunction

    function automatic void model_step(input bit rst, input logic [NN-1:0] c, input bit we);
        int occ, idx;
        if (rst) begin
            clear_cells();
            m_sx = 0; m_so = 0; m_phase = PH_PLAY; m_hold = 0;
            m_turn = 0; m_armed = 0; m_first = 0; m_draw = 0; m_ill = 0;
        end else begin
            m_ill = 1'b0;
            case (m_phase)
                PH_PLAY: begin
                    occ = 0;
                    for (int i = 0; i < NN; i++) if (m_cell[i] != 0) occ++;
                    if (has_line(1)) begin
                        if (m_sx < WS) m_sx++;
                        m_phase = (m_sx == WS) ? PH_OVER : PH_RES;
                    end else if (has_line(2)) begin
                        if (m_so < WS) m_so++;
                        m_phase = (m_so == WS) ? PH_OVER : PH_RES;
                    end else if (occ == NN) begin
                        m_draw  = 1'b1;
                        m_phase = PH_RES;
                    end else if (m_armed && we) begin
                        idx = 0;
                        for (int i = 0; i < NN; i++) if (c[i]) idx = i;
                        if ($countones(c) == 1 && m_cell[idx] == 0) begin
                            m_cell[idx] = m_turn ? 2 : 1;
                            m_turn = ~m_turn;
                        end else begin
                            m_ill = 1'b1;
                        end
                    end
                    m_armed = !we;
                end
                PH_RES: begin
                    m_hold++;
                    if (m_hold == HC) begin
                        clear_cells();
                        m_draw  = 1'b0;
                        m_first = ~m_first;
                        m_turn  = m_first;
                        m_armed = 1'b0;
                        m_hold  = 0;
                        m_phase = PH_PLAY;
                    end
                end
                default: ;
            endcase
        end
    endfunction

    function automatic logic [VW-1:0] model_vec();
        logic [NN-1:0] mx, mo;
        for (int i = 0; i < NN; i++) begin
            mx[i] = (m_cell[i] == 1);
            mo[i] = (m_cell[i] == 2);
        end
        return {mx, mo, m_turn, SW'(m_sx), SW'(m_so), (m_phase == PH_RES), m_draw, m_ill,
                (m_phase == PH_OVER)};
    endfunction

    task automatic tick(input bit rst, input logic [NN-1:0] c, input bit we);
        reset   = rst;
        C       = c;
        writeEn = we;
        @(posedge clk);
        model_step(rst, c, we);
        @(negedge clk);
    endtask

    task automatic play(input logic [NN-1:0] c);
        tick(1'b0, c, 1'b1);
        tick(1'b0, '0, 1'b0);
    endtask

    task automatic test_reset();
        tick(1'b1, '0, 1'b0);
        tick(1'b1, '0, 1'b0);
        n_cmp++;
        if (dut_vec !== '0) begin
            n_bad++; $display("FAIL reset_state: got %h want %h", dut_vec, {VW{1'b0}});
        end
        n_cmp++;
        if (dut_vec !== model_vec()) begin
            n_bad++; $display("FAIL reset_model: got %h want %h", dut_vec, model_vec());
        end
    endtask

    task automatic test_x_win_round();
        int hi;
        tick(1'b0, '0, 1'b0);
        play(9'h001); play(9'h008); play(9'h002); play(9'h010);
        tick(1'b0, 9'h004, 1'b1);
        n_cmp++;
        if (X !== 9'h007 || scorex !== 2'd0 || round_done !== 1'b0) begin
            n_bad++; $display("FAIL xwin_move: got X=%h sx=%0d rd=%b want X=007 sx=0 rd=0", X, scorex, round_done);
        end
        tick(1'b0, '0, 1'b0);
        n_cmp++;
        if (scorex !== 2'd1 || round_done !== 1'b1) begin
            n_bad++; $display("FAIL xwin_score: got sx=%0d rd=%b want sx=1 rd=1", scorex, round_done);
        end
        hi = 1;
        for (int k = 0; k < 10 && round_done; k++) begin
            tick(1'b0, '0, 1'b0);
            if (round_done) hi++;
        end
        n_cmp++;
        if (hi != HC) begin
            n_bad++; $display("FAIL xwin_hold: got %0d cycles want %0d", hi, HC);
        end
        n_cmp++;
        if (X !== '0 || O !== '0 || turn !== 1'b1) begin
            n_bad++; $display("FAIL xwin_clear: got X=%h O=%h turn=%b want 000 000 1", X, O, turn);
        end
        n_cmp++;
        if (dut_vec !== model_vec()) begin
            n_bad++; $display("FAIL xwin_model: got %h want %h", dut_vec, model_vec());
        end
    endtask

    task automatic test_illegal_occupied();
        tick(1'b0, '0, 1'b0);
        play(9'h010);
        tick(1'b0, 9'h010, 1'b1);
        n_cmp++;
        if (illegal !== 1'b1 || X !== '0 || turn !== 1'b0) begin
            n_bad++; $display("FAIL occ_illegal: got ill=%b X=%h turn=%b want 1 000 0", illegal, X, turn);
        end
        tick(1'b0, '0, 1'b0);
        n_cmp++;
        if (illegal !== 1'b0) begin
            n_bad++; $display("FAIL occ_pulse: got ill=%b want 0", illegal);
        end
        tick(1'b0, 9'h001, 1'b1);
        n_cmp++;
        if (X !== 9'h001 || turn !== 1'b1) begin
            n_bad++; $display("FAIL held_first: got X=%h turn=%b want 001 1", X, turn);
        end
        for (int k = 0; k < 2; k++) begin
            tick(1'b0, 9'h001, 1'b1);
            n_cmp++;
            if (X !== 9'h001 || turn !== 1'b1 || illegal !== 1'b0) begin
                n_bad++; $display("FAIL held_ignored: got X=%h turn=%b ill=%b want 001 1 0", X, turn, illegal);
            end
        end
        tick(1'b0, '0, 1'b0);
        n_cmp++;
        if (dut_vec !== model_vec()) begin
            n_bad++; $display("FAIL occ_model: got %h want %h", dut_vec, model_vec());
        end
    endtask

    task automatic test_illegal_multi();
        tick(1'b0, 9'h003, 1'b1);
        n_cmp++;
        if (illegal !== 1'b1 || X !== 9'h001 || O !== 9'h010) begin
            n_bad++; $display("FAIL multi_bit: got ill=%b X=%h O=%h want 1 001 010", illegal, X, O);
        end
        tick(1'b0, '0, 1'b0);
        n_cmp++;
        if (dut_vec !== model_vec()) begin
            n_bad++; $display("FAIL multi_model: got %h want %h", dut_vec, model_vec());
        end
    endtask

    task automatic test_draw();
        int mv [9] = '{0, 1, 2, 4, 3, 5, 7, 6, 8};
        logic [NN-1:0] cm;
        tick(1'b1, '0, 1'b0);
        tick(1'b0, '0, 1'b0);
        for (int k = 0; k < 9; k++) begin
            cm = '0;
            cm[mv[k]] = 1'b1;
            play(cm);
        end
        n_cmp++;
        if (X !== 9'h18D || O !== 9'h072 || draw !== 1'b1 || round_done !== 1'b1
            || scorex !== 2'd0 || scoreo !== 2'd0) begin
            n_bad++; $display("FAIL draw_detect: got X=%h O=%h dr=%b rd=%b sx=%0d so=%0d want 18d 072 1 1 0 0",
                              X, O, draw, round_done, scorex, scoreo);
        end
        for (int k = 0; k < HC; k++) tick(1'b0, '0, 1'b0);
        n_cmp++;
        if (draw !== 1'b0 || round_done !== 1'b0 || X !== '0 || O !== '0 || turn !== 1'b1) begin
            n_bad++; $display("FAIL draw_clear: got dr=%b rd=%b X=%h O=%h turn=%b want 0 0 000 000 1",
                              draw, round_done, X, O, turn);
        end
        n_cmp++;
        if (dut_vec !== model_vec()) begin
            n_bad++; $display("FAIL draw_model: got %h want %h", dut_vec, model_vec());
        end
    endtask

    task automatic test_match_over();
        tick(1'b1, '0, 1'b0);
        tick(1'b0, '0, 1'b0);
        play(9'h001); play(9'h008); play(9'h002); play(9'h010); play(9'h004);
        for (int k = 0; k < HC; k++) tick(1'b0, '0, 1'b0);
        tick(1'b0, '0, 1'b0);
        play(9'h008); play(9'h001); play(9'h010); play(9'h002); play(9'h100); play(9'h004);
        n_cmp++;
        if (scorex !== 2'd2 || gameOver !== 1'b1 || round_done !== 1'b0) begin
            n_bad++; $display("FAIL match_end: got sx=%0d go=%b rd=%b want 2 1 0", scorex, gameOver, round_done);
        end
        tick(1'b0, '0, 1'b0);
        tick(1'b0, 9'h020, 1'b1);
        tick(1'b0, '0, 1'b0);
        n_cmp++;
        if (X !== 9'h007 || O !== 9'h118 || gameOver !== 1'b1 || illegal !== 1'b0) begin
            n_bad++; $display("FAIL match_frozen: got X=%h O=%h go=%b ill=%b want 007 118 1 0", X, O, gameOver, illegal);
        end
        n_cmp++;
        if (dut_vec !== model_vec()) begin
            n_bad++; $display("FAIL match_model: got %h want %h", dut_vec, model_vec());
        end
        tick(1'b1, '0, 1'b0);
        n_cmp++;
        if (dut_vec !== '0) begin
            n_bad++; $display("FAIL match_reset: got %h want %h", dut_vec, {VW{1'b0}});
        end
    endtask

    task automatic test_reset_in_result();
        tick(1'b1, '0, 1'b0);
        tick(1'b0, '0, 1'b0);
        play(9'h001); play(9'h008); play(9'h002); play(9'h010); play(9'h004);
        tick(1'b0, '0, 1'b0);
        n_cmp++;
        if (round_done !== 1'b1) begin
            n_bad++; $display("FAIL rir_pre: got rd=%b want 1", round_done);
        end
        tick(1'b1, '0, 1'b0);
        n_cmp++;
        if (dut_vec !== '0) begin
            n_bad++; $display("FAIL rir_reset: got %h want %h", dut_vec, {VW{1'b0}});
        end
        tick(1'b0, '0, 1'b0);
        tick(1'b0, 9'h001, 1'b1);
        n_cmp++;
        if (X !== 9'h001 || turn !== 1'b1) begin
            n_bad++; $display("FAIL rir_play: got X=%h turn=%b want 001 1", X, turn);
        end
    endtask

    task automatic test_random();
        logic [NN-1:0] c;
        bit rst, we;
        tick(1'b1, '0, 1'b0);
        for (int cyc = 0; cyc < 1500; cyc++) begin
            rst = ($urandom_range(0, 299) == 0);
            we  = ($urandom_range(0, 1) == 1);
            if ($urandom_range(0, 9) == 0) begin
                c = NN'($urandom_range(0, (1 << NN) - 1));
            end else begin
                c = '0;
                c[$urandom_range(0, NN - 1)] = 1'b1;
            end
            tick(rst, c, we);
            n_cmp++;
            if (dut_vec !== model_vec()) begin
                n_bad++; $display("FAIL random_cycle %0d: got %h want %h", cyc, dut_vec, model_vec());
            end
        end
    endtask

    initial begin
        n_cmp   = 0;
        n_bad   = 0;
        reset   = 1'b1;
        C       = '0;
        writeEn = 1'b0;
        test_reset();
        test_x_win_round();
        test_illegal_occupied();
        test_illegal_multi();
        test_draw();
        test_match_over();
        test_reset_in_result();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
